// File: rtl/vmem_pkg.sv
// Shared types and default sizes for the MEM-stage vector memory sequencer.
// Imported by the sequencer RTL and its testbench.
package vmem_pkg;

    localparam int VMEM_LANES = 16;
    localparam int VMEM_DW    = 16;
    localparam int VMEM_AW    = 19;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef logic [VMEM_LANES-1:0][VMEM_DW-1:0] lane_vec_t;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Drives scalar and vector MEM-stage accesses over one DW-wide memory port,
// stalling the pipeline until the last beat is acknowledged.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int LANES = VMEM_LANES,
    parameter int DW    = VMEM_DW,
    parameter int AW    = VMEM_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic                     req_vector,
    input  logic [AW-1:0]            req_addr,
    input  logic [AW-1:0]            wdata_s,
    input  logic [LANES-1:0][DW-1:0] wdata_v,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     stall,
    output logic                     done,
    output logic [AW-1:0]            rdata_s,
    output logic [LANES-1:0][DW-1:0] rdata_v
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                     state, next_state;
    logic   [LW-1:0]            lane;
    logic   [LW-1:0]            last;
    logic                       op_write;
    logic                       op_vector;
    logic   [AW-1:0]            base;
    logic   [DW-1:0]            sdata_q;
    logic   [LANES-1:0][DW-1:0] vdata_q;

    logic accept;
    logic beat_done;

    assign accept    = (state == IDLE) && req_valid;
    assign beat_done = (state == ACCESS) && mem_ack;

    // NOTE: every output and next_state gets a default before the case, so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        stall      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                stall = req_valid & rst;
                if (req_valid) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = op_write;
                mem_addr  = base + AW'(lane);
                mem_wdata = op_vector ? vdata_q[lane] : sdata_q;
                stall     = 1'b1;
                if (mem_ack && (lane == last)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, as real hardware does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Beat sequencing: the lane counter holds while the memory withholds ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= '0;
            last      <= '0;
            op_write  <= 1'b0;
            op_vector <= 1'b0;
            base      <= '0;
        end else if (accept) begin
            lane      <= '0;
            last      <= req_vector ? LW'(LANES - 1) : '0;
            op_write  <= req_write;
            op_vector <= req_vector;
            base      <= req_addr;
        end else if (beat_done && (lane != last)) begin
            lane <= lane + 1'b1;
        end
    end

    // NOTE: the store-data capture registers are deliberately not reset; they
    // are only read during ACCESS, which is always preceded by a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            sdata_q <= wdata_s[DW-1:0];
            vdata_q <= wdata_v;
        end
    end

    // Load results persist until the next load is accepted; stores leave them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_s <= '0;
            rdata_v <= '0;
        end else if (accept && !req_write) begin
            rdata_s <= '0;
            rdata_v <= '0;
        end else if (beat_done && !op_write) begin
            if (op_vector) begin
                rdata_v[lane] <= mem_rdata;
            end else begin
                rdata_s <= AW'(mem_rdata);
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: stimulus queues expected beats and
// completions, a negedge monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_vector_mem_sequencer;
    import vmem_pkg::*;

    typedef struct {
        logic [18:0] addr;
        logic        we;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        int          stalls;
        logic [18:0] rs;
        lane_vec_t   rv;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_vector = 1'b0;
    logic [18:0] req_addr = '0;
    logic [18:0] wdata_s = '0;
    lane_vec_t   wdata_v = '0;
    logic        mem_req;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b1;
    logic [15:0] mem_rdata = '0;
    logic        stall;
    logic        done;
    logic [18:0] rdata_s;
    lane_vec_t   rdata_v;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t       beat_q[$];
    done_t       done_q[$];
    logic [15:0] mem_model[logic [18:0]];
    logic [18:0] exp_rs = '0;
    lane_vec_t   exp_rv = '0;

    vector_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_vector(req_vector),
        .req_addr  (req_addr),
        .wdata_s   (wdata_s),
        .wdata_v   (wdata_v),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .done      (done),
        .rdata_s   (rdata_s),
        .rdata_v   (rdata_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [15:0] mem_read(input logic [18:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Monitor: pops expected beats on each presented beat and expected results on done.
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (stall) stall_cnt++;
            if (mem_req) begin
                if (beat_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    check("beat_addr", 256'(mem_addr), 256'(beat_q[0].addr));
                    check("beat_we", 256'(mem_we), 256'(beat_q[0].we));
                    if (beat_q[0].we) check("beat_wdata", 256'(mem_wdata), 256'(beat_q[0].wdata));
                    if (mem_ack) begin
                        if (mem_we) mem_model[mem_addr] = mem_wdata;
                        void'(beat_q.pop_front());
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    check("stall_cycles", 256'(stall_cnt), 256'(done_q[0].stalls));
                    check("rdata_s", 256'(rdata_s), 256'(done_q[0].rs));
                    check("rdata_v", rdata_v, done_q[0].rv);
                    void'(done_q.pop_front());
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_stall", 256'(stall), 256'(0));
            check("idle_mem_req", 256'(mem_req), 256'(0));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b1;
        #1;
        check("rst_mem_req", 256'(mem_req), 256'(0));
        check("rst_stall", 256'(stall), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_rdata_v", rdata_v, 256'(0));
        check("rst_rdata_s", 256'(rdata_s), 256'(0));
        beat_q.delete();
        exp_rs = '0;
        exp_rv = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_done", 256'(done), 256'(0));
            check("rst_hold_stall", 256'(stall), 256'(0));
        end
        req_valid = 1'b0;
        rst       = 1'b1;
    endtask

    // Issue one access; exp_wait is the edges from drive to the first beat.
    task automatic run_op(input logic w, input logic v, input logic [18:0] a,
                          input logic [18:0] ws, input lane_vec_t wv, input int exp_wait,
                          input int gap_lane, input int gap_len, input int rst_lane,
                          input bit hold);
        int          n;
        int          gap_left;
        int          waited;
        beat_t       b;
        done_t       d;
        logic [18:0] gap_addr;
        logic [18:0] rst_addr;
        n        = v ? 16 : 1;
        gap_left = gap_len;
        gap_addr = a + 19'(gap_lane);
        rst_addr = a + 19'(rst_lane);
        for (int i = 0; i < n; i++) begin
            b.addr  = a + 19'(i);
            b.we    = w;
            b.wdata = v ? wv[i] : ws[15:0];
            beat_q.push_back(b);
        end
        if (!w) begin
            exp_rs = '0;
            exp_rv = '0;
            if (v) begin
                for (int i = 0; i < 16; i++) exp_rv[i] = mem_read(a + 19'(i));
            end else begin
                exp_rs = {3'b000, mem_read(a)};
            end
        end
        d.stalls = 1 + n + gap_len;
        d.rs     = exp_rs;
        d.rv     = exp_rv;
        if (rst_lane < 0) done_q.push_back(d);

        req_write  = w;
        req_vector = v;
        req_addr   = a;
        wdata_s    = ws;
        wdata_v    = wv;
        req_valid  = 1'b1;
        waited     = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!mem_req && waited < 8);
        check("accept_latency", 256'(waited), 256'(exp_wait));
        if (!hold) req_valid = 1'b0;

        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done) return;
            if (rst_lane >= 0 && mem_req && mem_addr == rst_addr) begin
                do_reset();
                return;
            end
            mem_rdata = mem_read(mem_addr);
            if (gap_left > 0 && mem_req && mem_addr == gap_addr) begin
                mem_ack = 1'b0;
                gap_left--;
            end else begin
                mem_ack = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        fail_now("op_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lane_vec_t wv_inc;
        lane_vec_t wv_none;
        lane_vec_t exp_inc;
        wv_none = '0;
        for (int i = 0; i < 16; i++) wv_inc[i] = 16'h1000 + 16'(i);
        exp_inc = wv_inc;
        mem_model[19'h00010] = 16'hBEEF;

        // Reset state, with req_valid asserted to show stall stays low in reset.
        req_valid = 1'b1;
        #12;
        check("reset_mem_req", 256'(mem_req), 256'(0));
        check("reset_mem_we", 256'(mem_we), 256'(0));
        check("reset_mem_addr", 256'(mem_addr), 256'(0));
        check("reset_mem_wdata", 256'(mem_wdata), 256'(0));
        check("reset_done", 256'(done), 256'(0));
        check("reset_stall", 256'(stall), 256'(0));
        check("reset_rdata_s", 256'(rdata_s), 256'(0));
        check("reset_rdata_v", rdata_v, 256'(0));
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3);

        // Scalar load of 0xBEEF at 0x00010.
        run_op(1'b0, 1'b0, 19'h00010, 19'h0, wv_none, 1, 0, 0, -1, 1'b0);
        idle(2);
        check("scalar_load_rdata_s", 256'(rdata_s), 256'(19'h0BEEF));

        // Vector store of 0x1000+i at 0x00100; load results unchanged.
        run_op(1'b1, 1'b1, 19'h00100, 19'h0, wv_inc, 1, 0, 0, -1, 1'b0);
        idle(2);

        // Vector load across the top of the address space.
        run_op(1'b0, 1'b1, 19'h7FFF8, 19'h0, wv_none, 1, 0, 0, -1, 1'b0);
        idle(2);
        check("wrap_lane0", 256'(rdata_v[0]), 256'(16'hA5A2));
        check("wrap_lane8", 256'(rdata_v[8]), 256'(16'h5A5A));

        // Vector load of the stored data with ack withheld 3 cycles on lane 5.
        run_op(1'b0, 1'b1, 19'h00100, 19'h0, wv_none, 1, 5, 3, -1, 1'b0);
        idle(2);
        check("gap_rdata_v", rdata_v, exp_inc);

        // Reset during lane 9 of a vector load, then a fresh scalar load.
        run_op(1'b0, 1'b1, 19'h00300, 19'h0, wv_none, 1, 0, 0, 9, 1'b0);
        idle(3);
        run_op(1'b0, 1'b0, 19'h00010, 19'h0, wv_none, 1, 0, 0, -1, 1'b0);
        idle(2);

        // Scalar store then scalar load of the same word, req_valid held throughout.
        run_op(1'b1, 1'b0, 19'h00200, 19'h21234, wv_none, 1, 0, 0, -1, 1'b1);
        run_op(1'b0, 1'b0, 19'h00200, 19'h0, wv_none, 2, 0, 0, -1, 1'b0);
        idle(2);
        check("b2b_rdata_s", 256'(rdata_s), 256'(19'h01234));

        check("beats_left", 256'(beat_q.size()), 256'(0));
        check("dones_left", 256'(done_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
